debounce_edge_sync: RTL
=======================

// Module: debounce_edge_sync
// PURPOSE
//   Front-end conditioning stage that feeds the team's D flip-flop capture/register stages.
//   Takes an asynchronous, bouncy 1-bit input (button, switch, external strobe) and
//   synchronises it into the clk domain. Rejects pulses shorter than STABLE_CYCLES.
//   Outputs a clean debounced level plus single-cycle rise/fall pulses that downstream
//   registers use as data or enable.
// PARAMETERS
//   SYNC_STAGES    2   synchroniser flop count; legal >= 2
//   STABLE_CYCLES  16  consecutive equal synchronised samples needed to accept a new level; legal >= 2
//   CNT_W          localparam = $clog2(STABLE_CYCLES), minimum 1; width of the stability counter
// PORTS
//   clk         in   1  rising-edge clock
//   rst_n       in   1  asynchronous, active-low reset
//   din_async   in   1  raw asynchronous input
//   dout        out  1  debounced level, registered
//   rise_pulse  out  1  one-cycle pulse when dout goes 0->1
//   fall_pulse  out  1  one-cycle pulse when dout goes 1->0
//   busy        out  1  high while a candidate level change is being qualified
// BEHAVIOUR
//   Reset
//   - One clock; rst_n is asynchronous and active-low.
//   - When rst_n is low: all sync flops = 0, cnt = 0, state = IDLE_LOW, and
//     dout/rise_pulse/fall_pulse/busy = 0, with no clock required.
//   - After release, the block behaves as if the input had been low.
//   Synchroniser
//   - din_async passes through a SYNC_STAGES flop chain; s = last stage.
//   - Only s is used by the logic below; din_async never reaches the FSM directly.
//   FSM states: IDLE_LOW, CHECK_HIGH, IDLE_HIGH, CHECK_LOW (all transitions on clk rise)
//   - IDLE_LOW:   s==1 -> CHECK_HIGH, cnt<=1; else stay.
//   - CHECK_HIGH: s==0 -> IDLE_LOW, cnt<=0 (glitch rejected, no pulse).
//                 s==1 and cnt==STABLE_CYCLES-1 -> IDLE_HIGH, dout<=1, rise_pulse<=1, cnt<=0.
//                 otherwise cnt<=cnt+1.
//   - IDLE_HIGH / CHECK_LOW: mirror of the above with s inverted; the accepting
//     transition gives dout<=0 and fall_pulse<=1.
//   Outputs
//   - busy = (state==CHECK_HIGH || state==CHECK_LOW), registered with state.
//   - rise_pulse/fall_pulse are high for exactly one cycle, coincident with the first
//     cycle of the new dout value. They are never both high, and never high outside
//     an accepting transition.
//   Latency
//   - din_async steps and stays stable before edge 1 -> dout changes at edge
//     SYNC_STAGES+STABLE_CYCLES (default 18).
//   - A run of s shorter than STABLE_CYCLES samples produces no dout change.
//   Counter
//   - Never exceeds STABLE_CYCLES-1 and never wraps.
//   Boundary cases
//   - Input high when rst_n releases: treated as a 0->1 change; rise_pulse fires
//     after the full latency.
//   - Bounce during CHECK_*: restarts qualification from the IDLE state and the
//     full window applies again.
//   - rst_n asserted mid-CHECK: immediate return to the reset values; no pulse
//     is emitted.
// TESTING
//   1 Reset with din_async=0, run 50 clks -> dout=0, busy=0, no pulses.
//   2 Defaults, din_async 0->1 before edge 1 and held -> dout=1 from edge 18;
//     rise_pulse high for exactly that one cycle; busy high during edges 3..17.
//   3 din_async high for 10 clks then low (glitch) -> dout stays 0, no
//     rise_pulse, busy returns 0.
//   4 Bounce: 5 toggles each 3 clks wide, then held high -> exactly one
//     rise_pulse, 18 edges after the final edge of din_async.
//   5 From dout=1, din_async 1->0 held -> dout=0 at edge 18 with one fall_pulse;
//     rise_pulse stays 0 throughout.
//   6 rst_n driven low between clock edges during CHECK_HIGH (cnt=7) -> outputs
//     go 0 at once; after release with din_async=1, rise_pulse appears 18 edges later.

Source files
------------

// File: rtl/debounce_edge_sync.sv
// ============================================================================
// debounce_edge_sync : synchroniser + debouncer with registered level and edge pulses
// Rev 1.0
// ============================================================================
`default_nettype none

module debounce_edge_sync #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din_async,
  output logic dout,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic busy
);

  localparam int CNT_W = ($clog2(STABLE_CYCLES) < 1) ? 1 : $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE_LOW   = 2'd0,
    CHECK_HIGH = 2'd1,
    IDLE_HIGH  = 2'd2,
    CHECK_LOW  = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dout_q, dout_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             busy_q, busy_d;

  // Bit 0 captures the raw input; only the last stage feeds the FSM.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din_async};
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;

    case (state_q)
      IDLE_LOW: begin
        if (s) begin
          state_d = CHECK_HIGH;
          cnt_d   = CNT_ONE;
        end
      end

      CHECK_HIGH: begin
        if (!s) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HIGH;
          dout_d  = 1'b1;
          rise_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      IDLE_HIGH: begin
        if (!s) begin
          state_d = CHECK_LOW;
          cnt_d   = CNT_ONE;
        end
      end

      CHECK_LOW: begin
        if (s) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LOW;
          dout_d  = 1'b0;
          fall_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = IDLE_LOW;
        cnt_d   = '0;
        dout_d  = 1'b0;
      end
    endcase

    // Busy is registered alongside the state it describes.
    busy_d = (state_d == CHECK_HIGH) || (state_d == CHECK_LOW);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  assign dout       = dout_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign busy       = busy_q;

endmodule

`default_nettype wire
